group_id_demap: RTL

GROUP_ID_DEMAP -- requirements
Module: group_id_demap

---
 rtl/group_id_demap.sv | 132 +++++++++++++
 1 files changed

// File: rtl/group_id_demap.sv
// group_id_demap: decodes a queue-group id into a one-hot source port and
// priority, relative to a one-hot destination port, through a 2-entry FIFO.
// Ports: clk, rst (async, active-high); in_valid/in_ready handshake with
//   in_dst_port[3:0], in_group_id[3:0]; out_valid/out_ready handshake with
//   out_src_port[3:0], out_pri[1:0], out_err; err_cnt[CNT_W-1:0].
// Option: define GROUP_ID_DEMAP_ERRCNT_EN to build the saturating error
//   counter; otherwise err_cnt is tied to 0.
module group_id_demap #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_dst_port,
    input  logic [3:0]       in_group_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_src_port,
    output logic [1:0]       out_pri,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0]  occ;
    logic [1:0]  occ_nxt;
    logic        rdy_q;
    logic        push;
    logic        pop;

    logic [3:0]  tail_src;
    logic [1:0]  tail_pri;
    logic        tail_err;

    logic [11:0] others;
    logic        bad_dst;
    logic [3:0]  dec_src;
    logic [1:0]  dec_pri;
    logic        dec_err;

    assign push      = in_valid & rdy_q;
    assign pop       = (occ != 2'd0) & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (occ != 2'd0);

    // The three non-destination ports, highest slot in the top nibble.
    always_comb begin
        others  = 12'd0;
        bad_dst = 1'b0;
        case (in_dst_port)
            4'b1000: others = {4'b0100, 4'b0010, 4'b0001};
            4'b0100: others = {4'b1000, 4'b0010, 4'b0001};
            4'b0010: others = {4'b1000, 4'b0100, 4'b0001};
            4'b0001: others = {4'b1000, 4'b0100, 4'b0010};
            default: bad_dst = 1'b1;
        endcase
    end

    always_comb begin
        dec_src = 4'd0;
        dec_pri = in_group_id[1:0];
        dec_err = bad_dst;
        case (in_group_id[3:2])
            2'd0:    dec_src = others[3:0];
            2'd1:    dec_src = others[7:4];
            2'd2:    dec_src = others[11:8];
            default: dec_err = 1'b1;
        endcase
        if (dec_err) begin
            dec_src = 4'd0;
            dec_pri = 2'd0;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // Head entry lives directly in the output registers; tail is the
    // second slot and only fills when the head is busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ          <= 2'd0;
            rdy_q        <= 1'b0;
            out_src_port <= 4'd0;
            out_pri      <= 2'd0;
            out_err      <= 1'b0;
            tail_src     <= 4'd0;
            tail_pri     <= 2'd0;
            tail_err     <= 1'b0;
        end else begin
            occ   <= occ_nxt;
            rdy_q <= (occ_nxt != 2'd2);
            if ((occ == 2'd0 && push) || (occ == 2'd1 && push && pop)) begin
                out_src_port <= dec_src;
                out_pri      <= dec_pri;
                out_err      <= dec_err;
            end else if (occ == 2'd2 && pop) begin
                out_src_port <= tail_src;
                out_pri      <= tail_pri;
                out_err      <= tail_err;
            end
            if (occ == 2'd1 && push && !pop) begin
                tail_src <= dec_src;
                tail_pri <= dec_pri;
                tail_err <= dec_err;
            end
        end
    end

`ifdef GROUP_ID_DEMAP_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push && dec_err && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
